// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode constants for the two-stage ALU pipeline.
//   F3_*   : Funct3 operation selects.
//   F7_ALT : Funct7 modifier selecting SUB (with ADD) or SRA (with SRL).
package alu_pkg;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SRL  = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic       F7_ALT  = 1'b1;

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU datapath.
//   rs1_i, rs2_i : operands (rs2_i low bits also serve as shift amount)
//   funct3_i     : operation select
//   funct7_i     : SUB / SRA modifier
//   rd_o         : result; bit WIDTH carries carry / not-borrow for ADD/SUB
//   zero_o       : rd_o[WIDTH-1:0] == 0
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rs1_i,
    input  logic [WIDTH-1:0] rs2_i,
    input  logic [2:0]       funct3_i,
    input  logic             funct7_i,
    output logic [WIDTH:0]   rd_o,
    output logic             zero_o
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   addsub;
    logic [WIDTH-1:0] sra;

    assign shamt = rs2_i[SHW-1:0];

    // SUB is RS1 + ~RS2 + 1, so the top bit is the not-borrow flag.
    assign op_b   = (funct7_i == F7_ALT) ? ~rs2_i : rs2_i;
    assign addsub = {1'b0, rs1_i} + {1'b0, op_b}
                  + {{WIDTH{1'b0}}, (funct7_i == F7_ALT)};
    assign sra    = $unsigned($signed(rs1_i) >>> shamt);

    always_comb begin
        rd_o = '0;
        case (funct3_i)
            F3_ADD:  rd_o = addsub;
            F3_SLL:  rd_o = {1'b0, rs1_i << shamt};
            F3_SLT:  rd_o = {{WIDTH{1'b0}}, ($signed(rs1_i) < $signed(rs2_i))};
            F3_SLTU: rd_o = {{WIDTH{1'b0}}, (rs1_i < rs2_i)};
            F3_XOR:  rd_o = {1'b0, rs1_i ^ rs2_i};
            F3_SRL:  rd_o = (funct7_i == F7_ALT) ? {1'b0, sra} : {1'b0, rs1_i >> shamt};
            F3_OR:   rd_o = {1'b0, rs1_i | rs2_i};
            F3_AND:  rd_o = {1'b0, rs1_i & rs2_i};
            default: rd_o = '0;
        endcase
    end

    assign zero_o = (rd_o[WIDTH-1:0] == '0);

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready ALU pipeline.
//   Stage 1 registers operands, opcode and tag; stage 2 registers the
//   alu_core result, zero flag and tag. Latency is two edges from accept
//   to out_valid; one op per cycle while out_ready is held high.
//   clk, rst          : clock, async active-high reset
//   in_valid/in_ready : input handshake (in_ready independent of in_valid)
//   RS1, RS2, Funct3, Funct7, in_tag : operation
//   out_valid/out_ready : output handshake
//   RD, zero, out_tag : result (RD[WIDTH] = carry / not-borrow)
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] RS1,
    input  logic [WIDTH-1:0] RS2,
    input  logic [2:0]       Funct3,
    input  logic             Funct7,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   RD,
    output logic             zero,
    output logic [TAG_W-1:0] out_tag
);

    // Stage 1
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_rs1_q,   s1_rs1_d;
    logic [WIDTH-1:0] s1_rs2_q,   s1_rs2_d;
    logic [2:0]       s1_f3_q,    s1_f3_d;
    logic             s1_f7_q,    s1_f7_d;
    logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;

    // Stage 2
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH:0]   s2_rd_q,    s2_rd_d;
    logic             s2_zero_q,  s2_zero_d;
    logic [TAG_W-1:0] s2_tag_q,   s2_tag_d;

    logic             s2_free;
    logic [WIDTH:0]   core_rd;
    logic             core_zero;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .rs1_i    (s1_rs1_q),
        .rs2_i    (s1_rs2_q),
        .funct3_i (s1_f3_q),
        .funct7_i (s1_f7_q),
        .rd_o     (core_rd),
        .zero_o   (core_zero)
    );

    // Stage 2 can take a new entry if it is empty or draining this edge.
    // When stage 1 holds data, s2_free is exactly "stage 1 advancing".
    assign s2_free  = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_free;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_rs1_d   = s1_rs1_q;
        s1_rs2_d   = s1_rs2_q;
        s1_f3_d    = s1_f3_q;
        s1_f7_d    = s1_f7_q;
        s1_tag_d   = s1_tag_q;
        s2_valid_d = s2_valid_q;
        s2_rd_d    = s2_rd_q;
        s2_zero_d  = s2_zero_q;
        s2_tag_d   = s2_tag_q;

        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_rs1_d = RS1;
                s1_rs2_d = RS2;
                s1_f3_d  = Funct3;
                s1_f7_d  = Funct7;
                s1_tag_d = in_tag;
            end
        end

        // Payload only loads on a real transfer so a stalled or drained
        // result never gets overwritten by stale stage-1 contents.
        if (s2_free) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_rd_d   = core_rd;
                s2_zero_d = core_zero;
                s2_tag_d  = s1_tag_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_rs1_q   <= '0;
            s1_rs2_q   <= '0;
            s1_f3_q    <= '0;
            s1_f7_q    <= 1'b0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_rd_q    <= '0;
            s2_zero_q  <= 1'b0;
            s2_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_rs1_q   <= s1_rs1_d;
            s1_rs2_q   <= s1_rs2_d;
            s1_f3_q    <= s1_f3_d;
            s1_f7_q    <= s1_f7_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_rd_q    <= s2_rd_d;
            s2_zero_q  <= s2_zero_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign RD        = s2_rd_q;
    assign zero      = s2_zero_q;
    assign out_tag   = s2_tag_q;

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [63:0] rs1 = '0, rs2 = '0;
    logic [2:0]  f3 = '0;
    logic        f7 = 1'b0;
    logic [3:0]  tag = '0;
    int          sel = 0;  // 0: WIDTH 32, 1: WIDTH 8, 2: WIDTH 64

    always #5 clk = ~clk;

    logic        ir32, ov32, z32, ir8, ov8, z8, ir64, ov64, z64;
    logic [32:0] rd32;
    logic [8:0]  rd8;
    logic [64:0] rd64;
    logic [3:0]  t32, t8, t64;

    alu_pipe #(.WIDTH(32), .TAG_W(4)) u32 (
        .clk(clk), .rst(rst), .in_valid(in_valid && sel == 0), .in_ready(ir32),
        .RS1(rs1[31:0]), .RS2(rs2[31:0]), .Funct3(f3), .Funct7(f7), .in_tag(tag),
        .out_valid(ov32), .out_ready(out_ready), .RD(rd32), .zero(z32), .out_tag(t32));
    alu_pipe #(.WIDTH(8), .TAG_W(4)) u8 (
        .clk(clk), .rst(rst), .in_valid(in_valid && sel == 1), .in_ready(ir8),
        .RS1(rs1[7:0]), .RS2(rs2[7:0]), .Funct3(f3), .Funct7(f7), .in_tag(tag),
        .out_valid(ov8), .out_ready(out_ready), .RD(rd8), .zero(z8), .out_tag(t8));
    alu_pipe #(.WIDTH(64), .TAG_W(4)) u64 (
        .clk(clk), .rst(rst), .in_valid(in_valid && sel == 2), .in_ready(ir64),
        .RS1(rs1), .RS2(rs2), .Funct3(f3), .Funct7(f7), .in_tag(tag),
        .out_valid(ov64), .out_ready(out_ready), .RD(rd64), .zero(z64), .out_tag(t64));

    // Selected instance's outputs, zero-extended to 65 bits.
    logic        o_rdy, o_v, o_z;
    logic [64:0] o_rd;
    logic [3:0]  o_tag;
    always_comb begin
        o_rdy = ir32; o_v = ov32; o_z = z32; o_rd = {32'b0, rd32}; o_tag = t32;
        if (sel == 1) begin
            o_rdy = ir8; o_v = ov8; o_z = z8; o_rd = {56'b0, rd8}; o_tag = t8;
        end else if (sel == 2) begin
            o_rdy = ir64; o_v = ov64; o_z = z64; o_rd = rd64; o_tag = t64;
        end
    end

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic int width_of(input int s);
        return (s == 1) ? 8 : (s == 2) ? 64 : 32;
    endfunction

    // Reference model: plain arithmetic on a w-bit view of the operands.
    typedef struct {
        logic [64:0] rd;
        logic        z;
        logic [3:0]  tag;
    } exp_t;

    function automatic exp_t model(input int w, input logic [2:0] op, input logic alt,
                                   input logic [63:0] a, input logic [63:0] b,
                                   input logic [3:0] t);
        exp_t        e;
        logic [64:0] m  = (65'd1 << w) - 65'd1;
        logic [64:0] am = {1'b0, a} & m;
        logic [64:0] bm = {1'b0, b} & m;
        logic signed [63:0] sa = $signed(a << (64 - w));
        logic signed [63:0] sb = $signed(b << (64 - w));
        int          sh = int'(b % 64'(w));
        logic [64:0] r;
        case (op)
            3'd0: r = alt ? am + ((~{1'b0, b}) & m) + 65'd1 : am + bm;
            3'd1: r = (am << sh) & m;
            3'd2: r = (sa < sb) ? 65'd1 : 65'd0;
            3'd3: r = (am < bm) ? 65'd1 : 65'd0;
            3'd4: r = am ^ bm;
            3'd5: r = alt ? ({1'b0, 64'(sa >>> (sh + 64 - w))} & m) : (am >> sh);
            3'd6: r = am | bm;
            default: r = am & bm;
        endcase
        e.rd  = r;
        e.z   = ((r & m) == 65'd0);
        e.tag = t;
        return e;
    endfunction

    exp_t        exp_q[$];
    bit          prev_stall = 0;
    logic [64:0] prev_rd;
    logic [3:0]  prev_tag;

    function automatic logic [63:0] rnd();
        case ($urandom % 5)
            0: return 64'd0;
            1: return '1;
            2: return {32'd0, $urandom};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // One cycle of randomized traffic (or draining) against the scoreboard.
    task automatic step(input bit rand_in);
        exp_t e;
        @(negedge clk);
        if (rand_in) begin
            in_valid  = ($urandom % 4) != 0;
            rs1 = rnd(); rs2 = rnd();
            f3  = 3'($urandom); f7 = 1'($urandom); tag = 4'($urandom);
            out_ready = ($urandom % 3) != 0;
        end else begin
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        #1;
        if (prev_stall) begin
            chk("hold_valid", 65'(o_v), 65'd1);
            chk("hold_rd", o_rd, prev_rd);
            chk("hold_tag", 65'(o_tag), 65'(prev_tag));
        end
        chk("in_ready", 65'(o_rdy), 65'((exp_q.size() < 2) || out_ready));
        if (o_v && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out_valid", 65'(o_v), 65'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rand_rd", o_rd, e.rd);
                chk("rand_zero", 65'(o_z), 65'(e.z));
                chk("rand_tag", 65'(o_tag), 65'(e.tag));
            end
        end
        if (in_valid && o_rdy)
            exp_q.push_back(model(width_of(sel), f3, f7, rs1, rs2, tag));
        prev_stall = o_v && !out_ready;
        prev_rd    = o_rd;
        prev_tag   = o_tag;
    endtask

    task automatic run_random(input int s, input int n);
        sel = s;
        prev_stall = 0;
        exp_q.delete();
        for (int i = 0; i < n; i++) step(1'b1);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1'b0);
        chk("rand_drain_empty", 65'(exp_q.size()), 65'd0);
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        logic [32:0] rd;
        logic        z;
    } vec_t;

    vec_t vt[13];

    initial begin
        vt[0]  = '{3'd0, 1'b0, 32'hFFFFFFFF, 32'h1,        4'd3,  33'h1_0000_0000, 1'b1};
        vt[1]  = '{3'd0, 1'b1, 32'd5,        32'd7,        4'd1,  33'h0_FFFF_FFFE, 1'b0};
        vt[2]  = '{3'd2, 1'b0, 32'hFFFFFFFF, 32'h1,        4'd2,  33'h1,           1'b0};
        vt[3]  = '{3'd3, 1'b0, 32'hFFFFFFFF, 32'h1,        4'd4,  33'h0,           1'b1};
        vt[4]  = '{3'd5, 1'b1, 32'h80000000, 32'h24,       4'd5,  33'h0_F800_0000, 1'b0};
        vt[5]  = '{3'd5, 1'b0, 32'h80000000, 32'h24,       4'd6,  33'h0_0800_0000, 1'b0};
        vt[6]  = '{3'd0, 1'b1, 32'd7,        32'd5,        4'd7,  33'h1_0000_0002, 1'b0};
        vt[7]  = '{3'd1, 1'b0, 32'h1,        32'hFFFFFFFF, 4'd8,  33'h0_8000_0000, 1'b0};
        vt[8]  = '{3'd4, 1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5, 4'd9,  33'h0,           1'b1};
        vt[9]  = '{3'd6, 1'b0, 32'hF0F00000, 32'h0000000F, 4'd10, 33'h0_F0F0_000F, 1'b0};
        vt[10] = '{3'd7, 1'b0, 32'h12345678, 32'h0F0F0F0F, 4'd11, 33'h0_0204_0608, 1'b0};
        vt[11] = '{3'd0, 1'b0, 32'd0,        32'd0,        4'd12, 33'h0,           1'b1};
        vt[12] = '{3'd0, 1'b1, 32'd0,        32'd0,        4'd13, 33'h1_0000_0000, 1'b1};

        // Reset state
        #1;
        chk("reset_out_valid", 65'(o_v), 65'd0);
        chk("reset_rd", o_rd, 65'd0);
        chk("reset_zero", 65'(o_z), 65'd0);
        chk("reset_tag", 65'(o_tag), 65'd0);
        chk("reset_in_ready", 65'(o_rdy), 65'd1);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors, one at a time, with latency check.
        sel = 0;
        foreach (vt[i]) begin
            @(negedge clk);
            in_valid = 1'b1; out_ready = 1'b1;
            rs1 = {32'd0, vt[i].a}; rs2 = {32'd0, vt[i].b};
            f3 = vt[i].f3; f7 = vt[i].f7; tag = vt[i].tag;
            #1 chk("vec_in_ready", 65'(o_rdy), 65'd1);
            @(negedge clk);
            in_valid = 1'b0;
            #1 chk("vec_early_valid", 65'(o_v), 65'd0);
            @(negedge clk);
            #1;
            chk("vec_valid", 65'(o_v), 65'd1);
            chk("vec_rd", o_rd, {32'd0, vt[i].rd});
            chk("vec_zero", 65'(o_z), 65'(vt[i].z));
            chk("vec_tag", 65'(o_tag), 65'(vt[i].tag));
        end

        // Back-to-back 8 ops with out_ready low for cycles 3..6.
        begin
            int sent = 0, got = 0;
            for (int c = 0; c < 40 && got < 8; c++) begin
                @(negedge clk);
                out_ready = !(c >= 3 && c <= 6);
                if (sent < 8) begin
                    in_valid = 1'b1;
                    rs1 = 64'(sent * 3); rs2 = 64'(sent);
                    f3 = 3'd0; f7 = 1'b0; tag = 4'(sent);
                end else begin
                    in_valid = 1'b0;
                end
                #1;
                if (c >= 3 && c <= 6) begin
                    chk("b2b_full_in_ready", 65'(o_rdy), 65'd0);
                    chk("b2b_hold_valid", 65'(o_v), 65'd1);
                    chk("b2b_hold_rd", o_rd, 65'd4);
                    chk("b2b_hold_tag", 65'(o_tag), 65'd1);
                end
                if (o_v && out_ready) begin
                    chk("b2b_rd", o_rd, 65'(4 * got));
                    chk("b2b_tag", 65'(o_tag), 65'(got));
                    got++;
                end
                if (in_valid && o_rdy) sent++;
            end
            chk("b2b_count", 65'(got), 65'd8);
        end

        // Async reset with both stages full.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1;
        rs1 = 64'd1; rs2 = 64'd1; f3 = 3'd0; f7 = 1'b0; tag = 4'd5;
        @(negedge clk);
        tag = 4'd6;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("pre_rst_valid", 65'(o_v), 65'd1);
        chk("pre_rst_full", 65'(o_rdy), 65'd0);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_valid", 65'(o_v), 65'd0);
        chk("async_rst_rd", o_rd, 65'd0);
        chk("async_rst_tag", 65'(o_tag), 65'd0);
        chk("async_rst_in_ready", 65'(o_rdy), 65'd1);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk("post_rst_no_stale", 65'(o_v), 65'd0);
        end

        // Randomized traffic at all three widths.
        run_random(1, 400);
        run_random(2, 400);
        run_random(0, 200);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
